buzzer_tone_gen: RTL
====================

// Module: buzzer_tone_gen
// PURPOSE
//  Parametrised piano tone generator: accepts timed note commands over a valid/ready handshake.
//  Decodes the 60-entry note code (C#3..B7) into a clock-accurate half-period count.
//  Drives a square wave on the buzzer pin for an exact number of milliseconds, then an optional silent gap.
//  Sits between the key/score sequencer and the buzzer pin; replaces a fixed 1 MHz divider-value lookup.
// PARAMETERS
//  CLK_HZ   100_000_000  iClk frequency in Hz; all tone and ms timing derives from it
//  DIV_W    20           half-period counter width; must hold CLK_HZ/276
//  GAP_MS   0            silent articulation gap after each note, in ms (0 = no gap)
// PORTS
//  iClk         in   1      clock
//  iReset_n     in   1      synchronous, active-low reset
//  iNoteValid   in   1      note command valid
//  iNote        in   8      note code: 0=repeat last, 1..59=C#3..B7, 99=rest, other=rest
//  iDurMs       in   16     note duration in ms
//  iStop        in   1      abort current note/gap immediately
//  oNoteReady   out  1      high only in IDLE; command accepted when iNoteValid & oNoteReady
//  oBuzzer      out  1      square-wave output to buzzer
//  oActive      out  1      high while in PLAY
//  oDone        out  1      1-cycle pulse when a note (incl. gap) completes normally
//  oHalfPeriod  out  DIV_W  half-period of latched note in iClk cycles; 0 = rest
// BEHAVIOUR
//  Reset: state=IDLE, oBuzzer=0, oActive=0, oDone=0, oNoteReady=1, oHalfPeriod=0, last-note=rest.
//  Note table: code k in 1..59 maps to the standard equal-temperament frequency f(k) (C#3=138 .. A4=440 .. B7=3951 Hz, integer Hz).
//  Half-period = CLK_HZ/(2*f(k)), integer truncation, computed at elaboration.
//  Code 0 reuses the last accepted non-zero code; 0 straight after reset = rest.
//  Codes 60..255 (incl. 99) = rest: full duration is timed, oBuzzer stays 0.
//  FSM IDLE -> PLAY -> (GAP) -> IDLE:
//   IDLE: on accept at edge N, latch half-period and duration, clear tone and ms prescalers.
//         Enter PLAY at N+1; oHalfPeriod valid from N+1.
//   PLAY: oActive=1; lasts exactly iDurMs*(CLK_HZ/1000) cycles.
//         oBuzzer starts 0 and toggles every half-period cycles (first toggle after half-period cycles).
//         On expiry: oBuzzer forced 0 the same edge (no wait for waveform edge).
//         Then GAP if GAP_MS>0, else IDLE.
//   GAP:  oBuzzer=0, oActive=0, lasts GAP_MS*(CLK_HZ/1000) cycles, then IDLE.
//   oDone pulses on the cycle the FSM re-enters IDLE after normal completion.
//  iDurMs=0: PLAY is skipped entirely (GAP still applies if GAP_MS>0); oDone pulses one cycle after accept (GAP_MS=0); no toggles.
//  iNoteValid while not ready: ignored, not queued.
//  iStop in PLAY/GAP: next edge -> IDLE, oBuzzer=0, oActive=0, no oDone, oHalfPeriod holds.
//  iStop in IDLE: no effect; iStop has priority over a same-cycle accept, which is dropped.
//  Reset mid-note: same as reset values next edge.
//  Counters saturate never: duration counter width covers 65535 ms at CLK_HZ.
// TESTING (sim CLK_HZ=1_000_000, 1000 cycles/ms, GAP_MS=0 unless stated)
//  1 Reset held 3 cycles -> oBuzzer=0, oActive=0, oDone=0, oNoteReady=1, oHalfPeriod=0.
//  2 Note 21, dur 2 -> oHalfPeriod=1136.
//    oBuzzer toggles every 1136 cycles; oActive high exactly 2000 cycles.
//    One oDone pulse; oNoteReady=1 after.
//  3 Note 59 dur 1, then note 0 dur 1 -> both oHalfPeriod=126.
//    Note 0 first after reset -> rest, oBuzzer=0 for 1000 cycles, oDone.
//  4 Note 99 and note 60, dur 1 each -> oHalfPeriod=0, oBuzzer=0 1000 cycles each, oDone each.
//  5 Note 1 dur 5, iStop at cycle 500 of PLAY -> oHalfPeriod=3623.
//    oBuzzer=0, oActive=0 next edge; no oDone; oNoteReady=1.
//    Valid pulses during PLAY ignored.
//  6 GAP_MS=1, note 21 dur 0 -> no toggles.
//    oBuzzer=0 for 1000-cycle gap; oDone on IDLE re-entry.

Source files
------------

// File: rtl/buzzer_tone_gen.sv
// Piano tone generator: accepts timed note commands over valid/ready and drives a
// square wave for an exact number of milliseconds, followed by an optional silent gap.
module buzzer_tone_gen #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned DIV_W  = 20,
    parameter int unsigned GAP_MS = 0
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iNoteValid,
    input  logic [7:0]       iNote,
    input  logic [15:0]      iDurMs,
    input  logic             iStop,
    output logic             oNoteReady,
    output logic             oBuzzer,
    output logic             oActive,
    output logic             oDone,
    output logic [DIV_W-1:0] oHalfPeriod
);

    localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
    localparam int unsigned PRE_W      = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
    localparam bit          HAS_GAP    = (GAP_MS != 0);

    // Integer-Hz equal-temperament frequencies; index 1 = C#3, 21 = A4, 59 = B7.
    localparam logic [59:0][11:0] FREQ_HZ = {
        12'd3951, 12'd3729, 12'd3520, 12'd3322, 12'd3135, 12'd2959,
        12'd2793, 12'd2637, 12'd2489, 12'd2349, 12'd2217,
        12'd2093, 12'd1975, 12'd1864, 12'd1760, 12'd1661, 12'd1567,
        12'd1479, 12'd1396, 12'd1318, 12'd1244, 12'd1174, 12'd1108,
        12'd1046, 12'd987,  12'd932,  12'd880,  12'd830,  12'd783,
        12'd739,  12'd698,  12'd659,  12'd622,  12'd587,  12'd554,
        12'd523,  12'd493,  12'd466,  12'd440,  12'd415,  12'd391,
        12'd369,  12'd349,  12'd329,  12'd311,  12'd293,  12'd277,
        12'd261,  12'd246,  12'd233,  12'd220,  12'd207,  12'd195,
        12'd184,  12'd174,  12'd164,  12'd155,  12'd146,  12'd138,
        12'd0
    };

    typedef logic [63:0][DIV_W-1:0] halfTable_t;

    function automatic halfTable_t buildHalfTable();
        halfTable_t t;
        t = '0;
        for (int k = 1; k < 60; k++) begin
            t[k] = DIV_W'(CLK_HZ / (2 * 32'(FREQ_HZ[k])));
        end
        return t;
    endfunction

    localparam halfTable_t HALF_TABLE = buildHalfTable();

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;
    logic               doneNext;
    logic               accept;
    logic [DIV_W-1:0]   noteHalf;
    logic [DIV_W-1:0]   halfPeriod;
    logic [DIV_W-1:0]   toneCnt;
    logic [PRE_W-1:0]   msPre;
    logic [15:0]        msLeft;
    logic               msTick;
    logic               timerExpire;
    logic               toneTick;

    // A stop request in IDLE swallows any same-cycle command.
    assign accept      = iNoteValid && (state == IDLE) && !iStop;
    assign noteHalf    = (iNote >= 8'd1 && iNote <= 8'd59) ? HALF_TABLE[iNote[5:0]] : '0;
    assign msTick      = (msPre == PRE_W'(CYC_PER_MS - 1));
    assign timerExpire = msTick && (msLeft == 16'd1);
    assign toneTick    = (halfPeriod != '0) && (toneCnt == halfPeriod - DIV_W'(1));

    assign oNoteReady  = (state == IDLE);
    assign oActive     = (state == PLAY);
    assign oHalfPeriod = halfPeriod;

    always_ff @(posedge iClk) begin
        // NOTE: reset is synchronous, so it is simply the first branch of the clocked process.
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns each output and no latch is inferred.
        nextState = state;
        doneNext  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (iDurMs != 16'd0) begin
                        nextState = PLAY;
                    end else if (HAS_GAP) begin
                        nextState = GAP;
                    end else begin
                        doneNext = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (iStop) begin
                    nextState = IDLE;
                end else if (timerExpire) begin
                    if (HAS_GAP) begin
                        nextState = GAP;
                    end else begin
                        nextState = IDLE;
                        doneNext  = 1'b1;
                    end
                end
            end
            GAP: begin
                if (iStop) begin
                    nextState = IDLE;
                end else if (timerExpire) begin
                    nextState = IDLE;
                    doneNext  = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        // NOTE: all state here uses <= so every register samples pre-edge values.
        if (!iReset_n) begin
            halfPeriod <= '0;
            toneCnt    <= '0;
            msPre      <= '0;
            msLeft     <= '0;
            oBuzzer    <= 1'b0;
            oDone      <= 1'b0;
        end else begin
            oDone <= doneNext;
            if (accept) begin
                // Code 0 keeps the previous half-period, which is the last real note.
                if (iNote != 8'd0) begin
                    halfPeriod <= noteHalf;
                end
                toneCnt <= '0;
                msPre   <= '0;
                msLeft  <= (iDurMs != 16'd0) ? iDurMs : 16'(GAP_MS);
                oBuzzer <= 1'b0;
            end else if (state != IDLE) begin
                if (nextState != state) begin
                    // Leaving PLAY/GAP: silence at once and preload the gap length.
                    oBuzzer <= 1'b0;
                    msPre   <= '0;
                    msLeft  <= 16'(GAP_MS);
                end else begin
                    msPre <= msTick ? '0 : msPre + PRE_W'(1);
                    if (msTick) begin
                        msLeft <= msLeft - 16'd1;
                    end
                    if (state == PLAY) begin
                        if (toneTick) begin
                            toneCnt <= '0;
                            oBuzzer <= !oBuzzer;
                        end else begin
                            toneCnt <= toneCnt + DIV_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule
